// File: rtl/button_event_ctrl.sv
// Per-button press/release/long/repeat event generator
// with a round-robin shared valid/ready event channel.
module button_event_ctrl #(
  parameter int NUM_BTN      = 4,
  parameter int TICK_DIV     = 100_000,
  parameter int LONG_TICKS   = 800,
  parameter int REPEAT_TICKS = 150,
  localparam int BW   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1,
  localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS,
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1,
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_BTN-1:0] i_btn_db,
  output logic               o_evt_valid,
  input  logic               i_evt_ready,
  output logic [BW-1:0]      o_evt_btn,
  output logic [1:0]         o_evt_type,
  output logic               o_drop
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_REPEAT
  } st_e;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

  logic [TW-1:0]      tick_q, tick_d;
  logic               tick;

  logic [NUM_BTN-1:0] btn_q, prev_q, armed_q, armed_d;
  logic               seen_q;
  logic [NUM_BTN-1:0] rise, fall;

  st_e                state_q [NUM_BTN];
  st_e                state_d [NUM_BTN];
  logic [CW-1:0]      cnt_q   [NUM_BTN];
  logic [CW-1:0]      cnt_d   [NUM_BTN];

  logic [NUM_BTN-1:0] post;
  logic [1:0]         post_type [NUM_BTN];

  logic [NUM_BTN-1:0] slot_q, slot_d;
  logic [1:0]         styp_q [NUM_BTN];
  logic [1:0]         styp_d [NUM_BTN];

  logic               valid_q, valid_d;
  logic [BW-1:0]      btn_o_q, btn_o_d;
  logic [1:0]         type_q, type_d;
  logic               drop_q, drop_d;
  logic [BW-1:0]      rr_q, rr_d;

  logic               accept, can_load, load, found;
  logic [BW-1:0]      start, win;
  int                 idx;

  function automatic logic [BW-1:0] nxt(input logic [BW-1:0] x);
    return (x == BW'(NUM_BTN - 1)) ? '0 : x + 1'b1;
  endfunction

  assign tick   = (tick_q == TICK_LAST);
  assign tick_d = tick ? '0 : tick_q + 1'b1;

  // Edges are qualified by armed so a button held through
  // reset yields no PRESS until it has been seen released.
  assign rise    = btn_q & ~prev_q & armed_q;
  assign fall    = ~btn_q & prev_q;
  assign armed_d = armed_q | ({NUM_BTN{seen_q}} & ~btn_q);

  // Tick divider and input sampling / edge-detect registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_q  <= '0;
      btn_q   <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      btn_q   <= i_btn_db;
      prev_q  <= btn_q;
      armed_q <= armed_d;
      seen_q  <= 1'b1;
    end
  end

  // Per-button FSM state and hold counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-button FSM next state; a release beats a timer expiry
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          if (rise[i]) begin
            state_d[i] = S_PRESSED;
            cnt_d[i]   = '0;
          end
        end
        S_PRESSED: begin
          if (fall[i]) begin
            state_d[i] = S_IDLE;
          end else if (tick) begin
            if (cnt_q[i] == LONG_LAST) begin
              state_d[i] = S_REPEAT;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        S_REPEAT: begin
          if (fall[i]) begin
            state_d[i] = S_IDLE;
          end else if (tick) begin
            if (cnt_q[i] == REP_LAST) cnt_d[i] = '0;
            else cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Per-button FSM outputs: event posts into the pending slot
  always_comb begin
    post = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      post_type[i] = EV_PRESS;
      unique case (state_q[i])
        S_IDLE: begin
          if (rise[i]) begin
            post[i]      = 1'b1;
            post_type[i] = EV_PRESS;
          end
        end
        S_PRESSED: begin
          if (fall[i]) begin
            post[i]      = 1'b1;
            post_type[i] = EV_RELEASE;
          end else if (tick && cnt_q[i] == LONG_LAST) begin
            post[i]      = 1'b1;
            post_type[i] = EV_LONG;
          end
        end
        S_REPEAT: begin
          if (fall[i]) begin
            post[i]      = 1'b1;
            post_type[i] = EV_RELEASE;
          end else if (tick && cnt_q[i] == REP_LAST) begin
            post[i]      = 1'b1;
            post_type[i] = EV_REPEAT;
          end
        end
        default: post[i] = 1'b0;
      endcase
    end
  end

  assign accept   = valid_q & i_evt_ready;
  assign can_load = ~valid_q | accept;
  // On a handshake the search already starts past the winner
  assign start    = accept ? nxt(btn_o_q) : rr_q;
  assign load     = can_load & found;

  // Round-robin search over pending slots
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_BTN; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      if (!found && slot_q[idx]) begin
        found = 1'b1;
        win   = BW'(idx);
      end
    end
  end

  // Slot update: grant empties a slot, a post refills it;
  // posting into a still-full slot is reported as a drop
  always_comb begin
    drop_d = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      slot_d[i] = slot_q[i];
      styp_d[i] = styp_q[i];
      if (load && win == BW'(i)) slot_d[i] = 1'b0;
      if (post[i]) begin
        slot_d[i] = 1'b1;
        styp_d[i] = post_type[i];
        if (slot_q[i] && !(load && win == BW'(i))) drop_d = 1'b1;
      end
    end
  end

  // Output channel next state
  always_comb begin
    valid_d = valid_q;
    btn_o_d = btn_o_q;
    type_d  = type_q;
    rr_d    = accept ? nxt(btn_o_q) : rr_q;
    if (load) begin
      valid_d = 1'b1;
      btn_o_d = win;
      type_d  = styp_q[win];
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // Pending slots, output channel and RR pointer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) styp_q[i] <= EV_PRESS;
      valid_q <= 1'b0;
      btn_o_q <= '0;
      type_q  <= EV_PRESS;
      drop_q  <= 1'b0;
      rr_q    <= '0;
    end else begin
      slot_q  <= slot_d;
      for (int i = 0; i < NUM_BTN; i++) styp_q[i] <= styp_d[i];
      valid_q <= valid_d;
      btn_o_q <= btn_o_d;
      type_q  <= type_d;
      drop_q  <= drop_d;
      rr_q    <= rr_d;
    end
  end

  assign o_evt_valid = valid_q;
  assign o_evt_btn   = btn_o_q;
  assign o_evt_type  = type_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: table of button steps plus
// hand sequences; accepted events checked against a queue.
module tb_button_event_ctrl;
  localparam int NB = 4;
  localparam int TD = 4;
  localparam int LT = 8;
  localparam int RT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = '0;
  logic       rdy = 1'b0;
  logic       valid;
  logic [1:0] ebtn;
  logic [1:0] etype;
  logic       drop;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .NUM_BTN(NB), .TICK_DIV(TD),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_btn_db(btn),
    .o_evt_valid(valid), .i_evt_ready(rdy),
    .o_evt_btn(ebtn), .o_evt_type(etype),
    .o_drop(drop)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ndrop = 0;
  logic [3:0] expq[$];
  int stamp[$];
  logic [3:0] e;

  typedef struct {
    bit         rst;
    logic [3:0] btn;
    bit         rdy;
    int         cyc;
    int         n;
    logic [23:0] ev;
  } step_t;

  step_t tbl[6];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every handshake pops one expected {btn,type}
  always @(negedge clk) begin
    if (rst_n) begin
      if (drop) ndrop <= ndrop + 1;
      if (valid && rdy) begin
        stamp.push_back(cyc);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL evt_unexpected: got btn=%0d type=%0d want none",
                   ebtn, etype);
        end else begin
          e = expq.pop_front();
          chk("evt_btn_type", int'({ebtn, etype}), int'(e));
        end
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk("drained_before_rst", expq.size(), 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(3);
  endtask

  initial begin
    int d0;
    int n0;
    tbl[0] = '{1'b0, 4'b0100, 1'b1, 20, 1, 24'h000008};
    tbl[1] = '{1'b0, 4'b0000, 1'b1, 10, 1, 24'h000009};
    tbl[2] = '{1'b0, 4'b0001, 1'b1, 72, 5, 24'h033320};
    tbl[3] = '{1'b0, 4'b0000, 1'b1, 10, 1, 24'h000001};
    tbl[4] = '{1'b1, 4'b1111, 1'b1, 10, 4, 24'h00C840};
    tbl[5] = '{1'b0, 4'b0000, 1'b1, 10, 4, 24'h00D951};

    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_btn", int'(ebtn), 0);
    chk("rst_type", int'(etype), 0);
    chk("rst_drop", int'(drop), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy = 1'b1;
    wait_cyc(3);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) do_reset();
      for (int k = 0; k < tbl[i].n; k++)
        expq.push_back(tbl[i].ev[4*k +: 4]);
      btn = tbl[i].btn;
      rdy = tbl[i].rdy;
      wait_cyc(tbl[i].cyc);
    end

    chk("stamp_count", stamp.size(), 16);
    if (stamp.size() >= 16) begin
      chk("long_delay", int'(stamp[3] - stamp[2] >= 29 &&
                             stamp[3] - stamp[2] <= 32), 1);
      for (int k = 3; k < 6; k++)
        chk("repeat_period", stamp[k+1] - stamp[k], 12);
      for (int k = 8; k < 11; k++)
        chk("b2b_press", stamp[k+1] - stamp[k], 1);
      for (int k = 12; k < 15; k++)
        chk("b2b_release", stamp[k+1] - stamp[k], 1);
    end

    // PRESS held on stalled output, RELEASE waits in the slot
    d0 = ndrop;
    rdy = 1'b0;
    expq.push_back(4'h4);
    expq.push_back(4'h5);
    btn = 4'b0010;
    wait_cyc(4);
    chk("hold_valid", int'(valid), 1);
    chk("hold_btn", int'(ebtn), 1);
    btn = 4'b0000;
    wait_cyc(6);
    chk("hold_valid2", int'(valid), 1);
    chk("hold_type2", int'(etype), 0);
    rdy = 1'b1;
    wait_cyc(6);
    chk("hold_no_drop", ndrop - d0, 0);
    chk("hold_idle", int'(valid), 0);

    // Second post into a full slot overwrites it: one drop
    d0 = ndrop;
    rdy = 1'b0;
    expq.push_back(4'hC);
    expq.push_back(4'hC);
    btn = 4'b1000;
    wait_cyc(4);
    btn = 4'b0000;
    wait_cyc(4);
    btn = 4'b1000;
    wait_cyc(6);
    chk("drop_once", ndrop - d0, 1);
    chk("drop_out_btn", int'(ebtn), 3);
    rdy = 1'b1;
    wait_cyc(6);
    expq.push_back(4'hD);
    btn = 4'b0000;
    wait_cyc(8);

    // Async reset while in REPEAT with an event on the output
    do_reset();
    rdy = 1'b0;
    btn = 4'b0001;
    wait_cyc(40);
    chk("pre_rst_valid", int'(valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_btn", int'(ebtn), 0);
    chk("mid_rst_type", int'(etype), 0);
    chk("mid_rst_drop", int'(drop), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy = 1'b1;
    n0 = stamp.size();
    wait_cyc(20);
    btn = 4'b0000;
    wait_cyc(10);
    chk("no_evt_after_rst", stamp.size() - n0, 0);
    expq.push_back(4'h0);
    expq.push_back(4'h1);
    btn = 4'b0001;
    wait_cyc(8);
    btn = 4'b0000;
    wait_cyc(8);

    for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
